imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00, instruction memory address at which the first loaded word is written.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a load session; sampled only in IDLE.
REQ-005 in_data  input  8  incoming program byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; a byte is transferred when in_valid and in_ready are both 1.
REQ-008 imem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-009 imem_addr  output  8  instruction memory write address.
REQ-010 imem_wdata  output  16  instruction word to write.
REQ-011 core_reset  output  1  holds the CPU datapath in reset while 1.
REQ-012 busy  output  1  load session in progress.
REQ-013 done  output  1  one-cycle pulse on successful load completion.
REQ-014 error  output  1  sticky checksum-failure flag.

Function
REQ-015 Byte stream format: count byte N (0..255 words), then N words sent high byte first, then (with REQ-030) one checksum byte.
REQ-016 States: IDLE, COUNT, HI, LO, WRITE, CHK; busy=1 in every state except IDLE.
REQ-017 IDLE: in_ready=0; start=1 moves to COUNT, clears error, sets addr pointer to BASE_ADDR and checksum accumulator to 0, and sets core_reset=1.
REQ-018 COUNT/HI/LO/CHK: in_ready=1; state advances only on a transfer; in_valid gaps of any length stall without side effects.
REQ-019 COUNT: accepted byte loads the word counter; N=0 goes to CHK (or completes per REQ-024 without the macro); otherwise goes to HI.
REQ-020 HI captures imem_wdata[15:8]; LO captures imem_wdata[7:0]; every data byte is XORed into the accumulator; the count byte is excluded.
REQ-021 WRITE: one cycle, in_ready=0, imem_we=1 with registered imem_addr and imem_wdata; write occurs the cycle after the LO byte is accepted.
REQ-022 After WRITE: address pointer increments modulo 256 (8'hFF wraps to 8'h00); counter decrements; goes to HI if words remain, else CHK (or completion).
REQ-023 CHK: accepted byte equal to accumulator -> success; unequal -> error=1, done=0, core_reset stays 1, return to IDLE.
REQ-024 Success: done=1 for exactly one cycle while returning to IDLE; core_reset goes 0 in the same cycle done is 1 and stays 0 until the next start or reset.
REQ-025 start while busy is ignored; imem_we is 0 in every state except WRITE.
REQ-026 imem_addr and imem_wdata hold their last values outside WRITE.

Reset
REQ-027 reset=1 forces IDLE from any state, including mid-session, aborting the load with no further writes.
REQ-028 Reset values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=16'h0000, core_reset=1, busy=0, done=0, error=0.
REQ-029 reset has priority over start and over any in-flight transfer in the same cycle.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: CHK state and trailing checksum byte present per REQ-023; undefined: no CHK state, no checksum byte, completion per REQ-024 immediately after the last WRITE (or after COUNT when N=0), error held at 0.

Verification
REQ-031 Assert reset 2 cycles -> core_reset=1, busy=0, in_ready=0, imem_we=0, error=0.
REQ-032 start; bytes 02,12,34,AB,CD,40 (LOADER_CHECKSUM_EN) -> writes (00,1234) then (01,ABCD), done pulse, core_reset=0, error=0.
REQ-033 Same stream with checksum 41 -> both writes occur, error=1, done never 1, core_reset stays 1.
REQ-034 BASE_ADDR=8'hFF, start; bytes 02,00,01,00,02 (macro undefined) -> writes (FF,0001) then (00,0002), done pulse.
REQ-035 start; bytes 00,00 with random in_valid gaps -> no imem_we, done pulse; extra start pulses during busy have no effect.
REQ-036 start; bytes 03,11,22,33, reset on the next cycle -> exactly one write (00,1122), then IDLE, core_reset=1, no further imem_we.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a program over a byte stream and writes it into
// instruction memory, holding the CPU core in reset while loading.
//
// Stream: count byte N (words), then N words high byte first, then (only
// when LOADER_CHECKSUM_EN is defined) one XOR checksum byte over the data.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start         - begin a load session (honoured only when idle)
//   in_data/in_valid/in_ready - byte stream handshake
//   imem_we/imem_addr/imem_wdata - instruction memory write port
//   core_reset    - holds the core in reset until a successful load
//   busy, done    - session in progress / one-cycle success pulse
//   error         - sticky checksum failure
//
// Build option: LOADER_CHECKSUM_EN enables the trailing checksum byte.
module imem_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [15:0] imem_wdata,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, WRITE, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, WRITE} state_t;
`endif

  state_t     state, next_state;
  logic [7:0] ptr;      // next write address
  logic [7:0] cnt;      // words still to write
  logic [7:0] hi_byte;  // high byte held until the low byte arrives
  logic       ok;       // session completes successfully this cycle
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] acc;
  logic       bad;
`endif

  assign imem_we = (state == WRITE);
  assign busy    = (state != IDLE);

  // Since in_ready is 1 in every byte-accepting state, a transfer there
  // reduces to in_valid.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    ok         = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    bad        = 1'b0;
`endif
    case (state)
      IDLE: if (start) next_state = COUNT;
      COUNT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data == 8'h00) begin
`ifdef LOADER_CHECKSUM_EN
            next_state = CHK;
`else
            next_state = IDLE;
            ok         = 1'b1;
`endif
          end else begin
            next_state = HI;
          end
        end
      end
      HI: begin
        in_ready = 1'b1;
        if (in_valid) next_state = LO;
      end
      LO: begin
        in_ready = 1'b1;
        if (in_valid) next_state = WRITE;
      end
      WRITE: begin
        if (cnt == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = CHK;
`else
          next_state = IDLE;
          ok         = 1'b1;
`endif
        end else begin
          next_state = HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = IDLE;
          if (in_data == acc) ok  = 1'b1;
          else                bad = 1'b1;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= BASE_ADDR;
      cnt        <= 8'h00;
      hi_byte    <= 8'h00;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 16'h0000;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc        <= 8'h00;
`endif
    end else begin
      state <= next_state;
      done  <= ok;
      case (state)
        IDLE: if (start) begin
          error      <= 1'b0;
          ptr        <= BASE_ADDR;
          core_reset <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
          acc        <= 8'h00;
`endif
        end
        COUNT: if (in_valid) cnt <= in_data;
        HI: if (in_valid) begin
          hi_byte <= in_data;
`ifdef LOADER_CHECKSUM_EN
          acc     <= acc ^ in_data;
`endif
        end
        // Address/data registers only change here so they hold their
        // values outside the write cycle.
        LO: if (in_valid) begin
          imem_addr  <= ptr;
          imem_wdata <= {hi_byte, in_data};
`ifdef LOADER_CHECKSUM_EN
          acc        <= acc ^ in_data;
`endif
        end
        WRITE: begin
          ptr <= ptr + 8'd1;
          cnt <= cnt - 8'd1;
        end
        default: ;
      endcase
      if (ok) core_reset <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (bad) error <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 00 and base FF) share the byte
// stream; expected writes go into a queue and are checked as they appear.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset, start0, start1, in_valid, sel;
  logic [7:0] in_data;
  logic rdy0, we0, cr0, busy0, done0, err0;
  logic rdy1, we1, cr1, busy1, done1, err1;
  logic [7:0] a0, a1;
  logic [15:0] d0, d1;
  logic rdy;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int dbase;

  typedef struct packed { logic [7:0] a; logic [15:0] d; } wr_t;
  wr_t expq[$];
  wr_t w;

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy0), .imem_we(we0), .imem_addr(a0),
    .imem_wdata(d0), .core_reset(cr0), .busy(busy0), .done(done0), .error(err0));

  imem_loader #(.BASE_ADDR(8'hFF)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy1), .imem_we(we1), .imem_addr(a1),
    .imem_wdata(d1), .core_reset(cr1), .busy(busy1), .done(done1), .error(err1));

  assign rdy = sel ? rdy1 : rdy0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor / scoreboard, plus done pulse counter.
  always @(negedge clk) begin
    if (done0 | done1) done_cnt++;
    if (we0 | we1) begin
      if (expq.size() == 0) begin
        chk("unexpected_write", {8'h00, (we1 ? a1 : a0), (we1 ? d1 : d0)}, 32'hFFFFFFFF);
      end else begin
        w = expq.pop_front();
        chk("write", {8'h00, (we1 ? a1 : a0), (we1 ? d1 : d0)}, {8'h00, w.a, w.d});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic which);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) chk("ready_timeout", 32'(rdy), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_core_reset", 32'(cr0), 32'd1);
    chk("rst_busy",       32'(busy0), 32'd0);
    chk("rst_in_ready",   32'(rdy0), 32'd0);
    chk("rst_we",         32'(we0), 32'd0);
    chk("rst_error",      32'(err0), 32'd0);
    chk("rst_done",       32'(done0), 32'd0);
    chk("rst_addr0",      32'(a0), 32'h00);
    chk("rst_wdata0",     32'(d0), 32'h0000);
    chk("rst_addr1",      32'(a1), 32'hFF);
    reset = 1'b0;
    @(negedge clk);

    // Two-word load at base 00.
    pulse(1'b0);
    chk("a_busy", 32'(busy0), 32'd1);
    chk("a_core_reset", 32'(cr0), 32'd1);
    expq.push_back('{8'h00, 16'h1234});
    expq.push_back('{8'h01, 16'hABCD});
    dbase = done_cnt;
    send(8'h02, 0); send(8'h12, 1); send(8'h34, 0); send(8'hAB, 2); send(8'hCD, 0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h40, 1);
`endif
    settle();
    chk("a_done_pulses", 32'(done_cnt - dbase), 32'd1);
    chk("a_core_reset_low", 32'(cr0), 32'd0);
    chk("a_error", 32'(err0), 32'd0);
    chk("a_idle", 32'(busy0), 32'd0);
    chk("a_writes_left", 32'(expq.size()), 32'd0);
    chk("a_addr_hold", 32'(a0), 32'h01);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: writes happen but the load fails.
    pulse(1'b0);
    chk("b_core_reset", 32'(cr0), 32'd1);
    expq.push_back('{8'h00, 16'h1234});
    expq.push_back('{8'h01, 16'hABCD});
    dbase = done_cnt;
    send(8'h02, 0); send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0);
    send(8'h41, 0);
    settle();
    chk("b_done_pulses", 32'(done_cnt - dbase), 32'd0);
    chk("b_error", 32'(err0), 32'd1);
    chk("b_core_reset_high", 32'(cr0), 32'd1);
    chk("b_idle", 32'(busy0), 32'd0);
    chk("b_writes_left", 32'(expq.size()), 32'd0);
`endif

    // Base FF: address wraps to 00.
    sel = 1'b1;
    pulse(1'b1);
    chk("c_error", 32'(err1), 32'd0);
    expq.push_back('{8'hFF, 16'h0001});
    expq.push_back('{8'h00, 16'h0002});
    dbase = done_cnt;
    send(8'h02, 0); send(8'h00, 0); send(8'h01, 0); send(8'h00, 0); send(8'h02, 0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h03, 0);
`endif
    settle();
    chk("c_done_pulses", 32'(done_cnt - dbase), 32'd1);
    chk("c_core_reset_low", 32'(cr1), 32'd0);
    chk("c_idle", 32'(busy1), 32'd0);
    chk("c_writes_left", 32'(expq.size()), 32'd0);
    sel = 1'b0;

    // Empty program, random gaps, stray starts while busy.
    pulse(1'b0);
    chk("d_error_cleared", 32'(err0), 32'd0);
    chk("d_core_reset", 32'(cr0), 32'd1);
    dbase = done_cnt;
    pulse(1'b0);
    pulse(1'b0);
    chk("d_still_count", 32'({busy0, rdy0}), 32'b11);
    send(8'h00, int'($urandom_range(1, 4)));
`ifdef LOADER_CHECKSUM_EN
    pulse(1'b0);
    chk("d_chk_busy", 32'(busy0), 32'd1);
    send(8'h00, int'($urandom_range(1, 4)));
`endif
    settle();
    chk("d_done_pulses", 32'(done_cnt - dbase), 32'd1);
    chk("d_core_reset_low", 32'(cr0), 32'd0);
    chk("d_idle", 32'(busy0), 32'd0);

    // Reset mid-session: only the first word lands.
    pulse(1'b0);
    expq.push_back('{8'h00, 16'h1122});
    dbase = done_cnt;
    send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("e_idle", 32'(busy0), 32'd0);
    chk("e_core_reset", 32'(cr0), 32'd1);
    chk("e_in_ready", 32'(rdy0), 32'd0);
    chk("e_wdata_reset", 32'(d0), 32'h0000);
    repeat (6) @(negedge clk);
    chk("e_writes_left", 32'(expq.size()), 32'd0);
    chk("e_done_pulses", 32'(done_cnt - dbase), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
